// File: rtl/ds_link_pkg.sv
// Shared DS-link definitions: control codes, character lengths, NULL hunt
// pattern and receiver state encoding (used by both link ends).
package ds_link_pkg;

   localparam logic [1:0] DS_FCT  = 2'b00;
   localparam logic [1:0] DS_EOP1 = 2'b01;
   localparam logic [1:0] DS_EOP2 = 2'b10;
   localparam logic [1:0] DS_ESC  = 2'b11;

   localparam logic [3:0] DS_DATA_LEN = 4'd8;
   localparam logic [3:0] DS_CTRL_LEN = 4'd2;

   // Tail of a NULL as received, oldest bit in the MSB: ESC data, P, FCT.
   localparam logic [6:0] DS_NULL_PAT = 7'b111_0100;

   typedef enum logic [1:0] {
      RX_HUNT,
      RX_PAR,
      RX_FLAG,
      RX_BITS
   } ds_rx_state_e;

endpackage

// File: rtl/ds_link_rx_if.sv
// Receiver-to-packet-layer bundle: characters, tokens, link status and errors.
interface ds_link_rx_if;
   logic       rx_valid;
   logic       rx_ctrl;
   logic [7:0] rx_data;
   logic       rx_fct;
   logic       rx_null;
   logic       link_up;
   logic       err_parity;
   logic       err_esc;
   logic       err_disc;

   modport master (
      output rx_valid, rx_ctrl, rx_data, rx_fct, rx_null,
      output link_up, err_parity, err_esc, err_disc
   );

   modport slave (
      input rx_valid, rx_ctrl, rx_data, rx_fct, rx_null,
      input link_up, err_parity, err_esc, err_disc
   );
endinterface

// File: rtl/ds_link_sync.sv
// Synchronizes the D/S lines and flags each D^S transition as a bit event,
// registered so the bit value and event are aligned for the framer.
module ds_link_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   input  logic s_i,
   output logic bit_evt_o,
   output logic bit_val_o
);

   logic [SYNC_STAGES-1:0] d_sync_q;
   logic [SYNC_STAGES-1:0] s_sync_q;
   logic                   ds_prev_q;
   logic                   bit_evt_q;
   logic                   bit_val_q;
   logic                   d_s;
   logic                   ds;

   assign d_s = d_sync_q[SYNC_STAGES-1];
   assign ds  = d_s ^ s_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_sync_q  <= '0;
         s_sync_q  <= '0;
         ds_prev_q <= 1'b0;
         bit_evt_q <= 1'b0;
         bit_val_q <= 1'b0;
      end else begin
         d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], d_i};
         s_sync_q  <= {s_sync_q[SYNC_STAGES-2:0], s_i};
         ds_prev_q <= ds;
         bit_evt_q <= ds ^ ds_prev_q;
         bit_val_q <= d_s;
      end
   end

   assign bit_evt_o = bit_evt_q;
   assign bit_val_o = bit_val_q;

endmodule

// File: rtl/ds_link_rx.sv
// IEEE 1355 DS link receiver: NULL hunt, character framing, control decode,
// disconnect detection. Parity checking is built when DS_LINK_RX_PARITY_EN is defined.
module ds_link_rx
   import ds_link_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DISC_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         d_in,
   input  logic         s_in,
   ds_link_rx_if.master rx
);

   localparam int unsigned DW = $clog2(DISC_TIMEOUT + 1);
   localparam logic [DW-1:0] DISC_LIM = DW'(DISC_TIMEOUT);

   logic bit_evt;
   logic bit_val;

   ds_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_i       (d_in),
      .s_i       (s_in),
      .bit_evt_o (bit_evt),
      .bit_val_o (bit_val)
   );

   ds_rx_state_e  state_q;
   logic [6:0]    win_q, win_d;
   logic [7:0]    sh_q, sh_d;
   logic [1:0]    code_d;
   logic [3:0]    cnt_q;
   logic          ctl_q;
   logic          esc_q;
   logic [DW-1:0] disc_q, disc_d;
   logic          valid_q, ctrl_q, fct_q, null_q, link_q, eesc_q, edisc_q;
   logic [7:0]    data_q;
   logic          perr, eerr, derr;
`ifdef DS_LINK_RX_PARITY_EN
   logic          p_q, acc_q, prev_par_q, epar_q;
`endif

   // Data arrives LSB first, so shifting into the MSB leaves the byte in order;
   // a 2-bit control code lands in [7:6] with the first bit in [6].
   always_comb begin
      win_d  = {win_q[5:0], bit_val};
      sh_d   = {bit_val, sh_q[7:1]};
      code_d = {sh_d[6], sh_d[7]};
      disc_d = disc_q + DW'(1);
      perr   = 1'b0;
      eerr   = 1'b0;
      derr   = !bit_evt && link_q && (disc_d == DISC_LIM);
      if (bit_evt && state_q == RX_BITS && cnt_q == 4'd1 && esc_q)
         eerr = ctl_q ? (code_d != DS_FCT) : 1'b1;
`ifdef DS_LINK_RX_PARITY_EN
      if (bit_evt && state_q == RX_FLAG)
         perr = !(prev_par_q ^ p_q ^ bit_val);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RX_HUNT;
         win_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         ctl_q   <= 1'b0;
         esc_q   <= 1'b0;
         disc_q  <= '0;
         valid_q <= 1'b0;
         ctrl_q  <= 1'b0;
         data_q  <= '0;
         fct_q   <= 1'b0;
         null_q  <= 1'b0;
         link_q  <= 1'b0;
         eesc_q  <= 1'b0;
         edisc_q <= 1'b0;
`ifdef DS_LINK_RX_PARITY_EN
         p_q        <= 1'b0;
         acc_q      <= 1'b0;
         prev_par_q <= 1'b0;
         epar_q     <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         fct_q   <= 1'b0;
         null_q  <= 1'b0;
         eesc_q  <= eerr;
         edisc_q <= derr;
`ifdef DS_LINK_RX_PARITY_EN
         epar_q  <= perr;
`endif
         if (bit_evt || !link_q) disc_q <= '0;
         else                    disc_q <= disc_d;

         if (bit_evt) begin
            case (state_q)
               RX_HUNT: begin
                  win_q <= win_d;
                  if (win_d == DS_NULL_PAT) begin
                     state_q <= RX_PAR;
                     null_q  <= 1'b1;
                     link_q  <= 1'b1;
                     esc_q   <= 1'b0;
`ifdef DS_LINK_RX_PARITY_EN
                     prev_par_q <= 1'b0;
`endif
                  end
               end
               RX_PAR: begin
`ifdef DS_LINK_RX_PARITY_EN
                  p_q <= bit_val;
`endif
                  state_q <= RX_FLAG;
               end
               RX_FLAG: begin
                  ctl_q   <= bit_val;
                  cnt_q   <= bit_val ? DS_CTRL_LEN : DS_DATA_LEN;
                  state_q <= RX_BITS;
`ifdef DS_LINK_RX_PARITY_EN
                  acc_q <= 1'b0;
`endif
               end
               RX_BITS: begin
                  sh_q  <= sh_d;
                  cnt_q <= cnt_q - 4'd1;
`ifdef DS_LINK_RX_PARITY_EN
                  acc_q <= acc_q ^ bit_val;
`endif
                  if (cnt_q == 4'd1) begin
                     state_q <= RX_PAR;
`ifdef DS_LINK_RX_PARITY_EN
                     prev_par_q <= acc_q ^ bit_val;
`endif
                     if (!ctl_q) begin
                        if (!esc_q) begin
                           valid_q <= 1'b1;
                           ctrl_q  <= 1'b0;
                           data_q  <= sh_d;
                        end
                     end else begin
                        case (code_d)
                           DS_FCT: begin
                              if (esc_q) null_q <= 1'b1;
                              else       fct_q  <= 1'b1;
                              esc_q <= 1'b0;
                           end
                           DS_ESC: esc_q <= 1'b1;
                           DS_EOP1, DS_EOP2: begin
                              if (!esc_q) begin
                                 valid_q <= 1'b1;
                                 ctrl_q  <= 1'b1;
                                 data_q  <= {6'b0, code_d};
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
               end
               default: state_q <= RX_HUNT;
            endcase
         end

         // Any error overrides the state update above and restarts the hunt.
         if (perr || eerr || derr) begin
            state_q <= RX_HUNT;
            link_q  <= 1'b0;
            esc_q   <= 1'b0;
            win_q   <= '0;
         end
      end
   end

   assign rx.rx_valid = valid_q;
   assign rx.rx_ctrl  = ctrl_q;
   assign rx.rx_data  = data_q;
   assign rx.rx_fct   = fct_q;
   assign rx.rx_null  = null_q;
   assign rx.link_up  = link_q;
   assign rx.err_esc  = eesc_q;
   assign rx.err_disc = edisc_q;
`ifdef DS_LINK_RX_PARITY_EN
   assign rx.err_parity = epar_q;
`else
   assign rx.err_parity = 1'b0;
`endif

endmodule
